// File: rtl/issue_arbiter_pkg.sv
// Shared constants for the issue-queue arbiter: default size and the "no grant" index.
// Consumers compare the granted index against ARB_NONE before using it.
package issue_arbiter_pkg;

  localparam int ARB_N     = 16;
  localparam int ARB_IDX_W = 5;

  localparam logic [ARB_IDX_W-1:0] ARB_NONE = ARB_IDX_W'(ARB_N);

endpackage

// File: rtl/issue_arbiter_prio_enc.sv
// Lowest-index-wins priority encoder: one-hot winner, binary index and any-request flag.
// With no request the index reports W, which is the arbiter's "no grant" code.
module prio_enc
  import issue_arbiter_pkg::*;
#(
  parameter int W    = ARB_N,
  parameter int IDXW = ARB_IDX_W
) (
  input  logic [W-1:0]    req,
  output logic [W-1:0]    onehot,
  output logic [IDXW-1:0] index,
  output logic            any
);

  // Scan from the top down so the last hit, i.e. the lowest set index, wins.
  always_comb begin
    onehot = '0;
    index  = IDXW'(W);
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        index     = IDXW'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/issue_arbiter.sv
// Combinational N-way issue arbiter returning the winner as one-hot and binary index.
// Define ROUND_ROBIN_EN for a rotating-priority pointer; otherwise fixed lowest-index priority.
module issue_arbiter
  import issue_arbiter_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int IDX_W = ARB_IDX_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N-1:0]     ready,
  input  logic             accept,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] granted,
  output logic             valid
);

`ifdef ROUND_ROBIN_EN

  logic [IDX_W-1:0] ptr;
  logic [N-1:0]     ptr_mask;
  logic [N-1:0]     masked_ready;

  logic [N-1:0]     hi_onehot;
  logic [IDX_W-1:0] hi_index;
  logic             hi_any;
  logic [N-1:0]     all_onehot;
  logic [IDX_W-1:0] all_index;
  logic             all_any;

  always_comb begin
    ptr_mask = '0;
    for (int i = 0; i < N; i++) begin
      ptr_mask[i] = (IDX_W'(i) >= ptr);
    end
  end

  assign masked_ready = ready & ptr_mask;

  prio_enc #(.W(N), .IDXW(IDX_W)) u_enc_hi (
    .req    (masked_ready),
    .onehot (hi_onehot),
    .index  (hi_index),
    .any    (hi_any)
  );

  prio_enc #(.W(N), .IDXW(IDX_W)) u_enc_all (
    .req    (ready),
    .onehot (all_onehot),
    .index  (all_index),
    .any    (all_any)
  );

  // Requests at or above ptr take precedence; the unmasked search covers the wrap-around.
  assign grant   = hi_any ? hi_onehot : all_onehot;
  assign granted = hi_any ? hi_index  : all_index;
  assign valid   = all_any;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ptr <= '0;
    end else if (accept && valid) begin
      ptr <= (granted == IDX_W'(N - 1)) ? '0 : granted + IDX_W'(1);
    end
  end

`else

  logic unused_rr_inputs;

  assign unused_rr_inputs = ^{CLK, RESET, accept};

  prio_enc #(.W(N), .IDXW(IDX_W)) u_enc (
    .req    (ready),
    .onehot (grant),
    .index  (granted),
    .any    (valid)
  );

`endif

endmodule

// File: tb/tb_issue_arbiter.sv
// Directed self-checking bench for issue_arbiter, fixed-priority build by default.
// Rotating-priority checks are compiled in when ROUND_ROBIN_EN is defined.
module tb_issue_arbiter;

  logic        CLK;
  logic        RESET;
  logic [15:0] ready;
  logic        accept;
  logic [15:0] grant;
  logic [4:0]  granted;
  logic        valid;

  int tests_run;
  int tests_failed;

  issue_arbiter dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .ready   (ready),
    .accept  (accept),
    .grant   (grant),
    .granted (granted),
    .valid   (valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic [15:0] ready_v, input logic accept_v);
    ready  = ready_v;
    accept = accept_v;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] exp_grant,
                             input logic [4:0] exp_granted, input logic exp_valid);
    tests_run++;
    assert (grant === exp_grant) else begin
      tests_failed++;
      $error("[TB] FAIL %s grant observed=%h expected=%h", tag, grant, exp_grant);
    end
    tests_run++;
    assert (granted === exp_granted) else begin
      tests_failed++;
      $error("[TB] FAIL %s granted observed=%0d expected=%0d", tag, granted, exp_granted);
    end
    tests_run++;
    assert (valid === exp_valid) else begin
      tests_failed++;
      $error("[TB] FAIL %s valid observed=%b expected=%b", tag, valid, exp_valid);
    end
  endtask

  initial begin
    logic [15:0] one_bit;
    logic [15:0] upper_bits;
    tests_run    = 0;
    tests_failed = 0;
    RESET  = 1'b0;
    ready  = '0;
    accept = 1'b0;

    applyStimulus(16'h0000, 1'b0);
    checkOutput("reset_empty", 16'h0000, 5'd16, 1'b0);
    applyStimulus(16'hFFFF, 1'b0);
    checkOutput("reset_full", 16'h0001, 5'd0, 1'b1);

    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    applyStimulus(16'h0000, 1'b0);
    checkOutput("empty", 16'h0000, 5'd16, 1'b0);
    applyStimulus(16'b1010_0000_0000_1000, 1'b0);
    checkOutput("mixed", 16'h0008, 5'd3, 1'b1);
    applyStimulus(16'h8000, 1'b0);
    checkOutput("top_only", 16'h8000, 5'd15, 1'b1);
    applyStimulus(16'hFFFF, 1'b0);
    checkOutput("all_ready", 16'h0001, 5'd0, 1'b1);
    applyStimulus(16'h0006, 1'b0);
    checkOutput("pair_low", 16'h0002, 5'd1, 1'b1);
    applyStimulus(16'hC000, 1'b0);
    checkOutput("pair_high", 16'h4000, 5'd14, 1'b1);
    applyStimulus(16'h0F00, 1'b0);
    checkOutput("nibble", 16'h0100, 5'd8, 1'b1);

    // Each single request, alone and with every higher requester also set.
    for (int i = 0; i < 16; i++) begin
      one_bit    = 16'h0001 << i;
      upper_bits = 16'hFFFF << i;
      applyStimulus(one_bit, 1'b0);
      checkOutput($sformatf("single_%0d", i), one_bit, 5'(i), 1'b1);
      applyStimulus(upper_bits, 1'b0);
      checkOutput($sformatf("upper_%0d", i), one_bit, 5'(i), 1'b1);
    end

    // Grant follows ready mid-cycle without waiting for a clock edge.
    applyStimulus(16'h0400, 1'b0);
    checkOutput("midcycle_a", 16'h0400, 5'd10, 1'b1);
    applyStimulus(16'h0410, 1'b0);
    checkOutput("midcycle_b", 16'h0010, 5'd4, 1'b1);

`ifdef ROUND_ROBIN_EN
    @(negedge CLK);
    applyStimulus(16'h0009, 1'b1);
    checkOutput("rr_ptr0", 16'h0001, 5'd0, 1'b1);
    @(negedge CLK);
    checkOutput("rr_ptr1", 16'h0008, 5'd3, 1'b1);
    @(negedge CLK);
    checkOutput("rr_ptr4_wrap", 16'h0001, 5'd0, 1'b1);
    @(negedge CLK);
    checkOutput("rr_ptr1_again", 16'h0008, 5'd3, 1'b1);

    applyStimulus(16'h0010, 1'b1);
    checkOutput("rr_take4", 16'h0010, 5'd4, 1'b1);
    @(negedge CLK);
    applyStimulus(16'h0021, 1'b0);
    checkOutput("rr_ptr5", 16'h0020, 5'd5, 1'b1);

    applyStimulus(16'h0000, 1'b1);
    checkOutput("rr_accept_empty", 16'h0000, 5'd16, 1'b0);
    @(negedge CLK);
    applyStimulus(16'h0021, 1'b0);
    checkOutput("rr_ptr5_held", 16'h0020, 5'd5, 1'b1);
    @(negedge CLK);
    checkOutput("rr_no_accept_hold", 16'h0020, 5'd5, 1'b1);

    #2;
    RESET = 1'b0;
    #1;
    checkOutput("rr_async_reset", 16'h0001, 5'd0, 1'b1);
    @(negedge CLK);
    RESET = 1'b1;
    applyStimulus(16'h0021, 1'b0);
    checkOutput("rr_after_reset", 16'h0001, 5'd0, 1'b1);

    applyStimulus(16'h8000, 1'b1);
    @(negedge CLK);
    applyStimulus(16'h8001, 1'b0);
    checkOutput("rr_wrap_15", 16'h0001, 5'd0, 1'b1);
`else
    @(negedge CLK);
    applyStimulus(16'h0009, 1'b1);
    checkOutput("fixed_accept_0", 16'h0001, 5'd0, 1'b1);
    @(negedge CLK);
    checkOutput("fixed_accept_1", 16'h0001, 5'd0, 1'b1);
    @(negedge CLK);
    checkOutput("fixed_accept_2", 16'h0001, 5'd0, 1'b1);
    applyStimulus(16'h0021, 1'b0);
    checkOutput("fixed_0021", 16'h0001, 5'd0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
